// File: rtl/demosaic_pkg.sv
// Shared constants for the demosaic frame sequencer: FSM state codes,
// coordinate width and default datapath depth.
package demosaic_pkg;

  localparam int unsigned COORD_W      = 16;
  localparam int unsigned PIPE_DLY_DEF = 2;
  localparam int unsigned STATE_W      = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_FILL  = 3'd1;
  localparam logic [STATE_W-1:0] S_RUN   = 3'd2;
  localparam logic [STATE_W-1:0] S_FLUSH = 3'd3;
  localparam logic [STATE_W-1:0] S_DRAIN = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

endpackage

// File: rtl/demosaic_frame_ctrl_if.sv
// Pixel handshake, datapath control and output-coordinate bundle between
// the stream source/sink (master) and the frame sequencer (slave).
interface demosaic_frame_ctrl_if;
  import demosaic_pkg::*;

  logic               iStart;
  logic               iValid;
  logic               oReady;
  logic               iOutReady;
  logic               oShiftEn;
  logic               oPadSel;
  logic [1:0]         oPhase;
  logic               oOutValid;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic               oBusy;
  logic               oDone;

  modport master (
    output iStart, iValid, iOutReady,
    input  oReady, oShiftEn, oPadSel, oPhase, oOutValid, oX, oY, oBusy, oDone
  );

  modport slave (
    input  iStart, iValid, iOutReady,
    output oReady, oShiftEn, oPadSel, oPhase, oOutValid, oX, oY, oBusy, oDone
  );

endinterface

// File: rtl/demosaic_xy_counter.sv
// Raster column/row counter: column wraps after WIDTH-1 and bumps the row.
// Synchronous clear has priority over enable.
module demosaic_xy_counter #(
  parameter int unsigned WIDTH   = 320,
  parameter int unsigned COORD_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == COORD_W'(WIDTH - 1)) begin
        x <= '0;
        y <= y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer for the two-line-tap Bayer demosaic: fills the line buffers,
// streams the frame, flushes with zero pads and drains the datapath pipeline.
module demosaic_frame_ctrl
  import demosaic_pkg::*;
#(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned FILL_LINES = 2,
  parameter int unsigned PIPE_DLY   = PIPE_DLY_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  demosaic_frame_ctrl_if.slave bus
);

  localparam logic [31:0] FILL_PIX  = 32'(FILL_LINES * WIDTH);
  localparam logic [31:0] FRAME_PIX = 32'(WIDTH * HEIGHT);
  localparam int unsigned DRAIN_W   = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;

  logic [STATE_W-1:0]  state_q, state_d;
  logic [31:0]         in_cnt_q, pad_cnt_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [PIPE_DLY-1:0] dly_q;
  logic [COORD_W-1:0]  sx, sy;

  logic       start_c, ready_c, shift_c, pad_c, post_c;
  logic [1:0] phase_c;

  // Next state and per-cycle handshake/datapath controls
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    ready_c = 1'b0;
    shift_c = 1'b0;
    pad_c   = 1'b0;
    post_c  = 1'b0;
    phase_c = 2'b00;
    case (state_q)
      S_IDLE: begin
        start_c = bus.iStart;
        if (bus.iStart) state_d = S_FILL;
      end
      S_FILL: begin
        ready_c = 1'b1;
        shift_c = bus.iValid;
        if (shift_c && (in_cnt_q + 32'd1 == FILL_PIX)) state_d = S_RUN;
      end
      S_RUN: begin
        ready_c = bus.iOutReady;
        shift_c = bus.iValid & bus.iOutReady;
        post_c  = shift_c;
        phase_c = {sy[0], sx[0]};
        if (shift_c && (in_cnt_q + 32'd1 == FRAME_PIX)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        pad_c   = 1'b1;
        shift_c = bus.iOutReady;
        post_c  = shift_c;
        phase_c = {sy[0], sx[0]};
        if (shift_c && (pad_cnt_q + 32'd1 == FILL_PIX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(PIPE_DLY - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      pad_cnt_q <= '0;
      drain_q   <= '0;
      dly_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_c) begin
        in_cnt_q  <= '0;
        pad_cnt_q <= '0;
      end else if (shift_c && pad_c) begin
        pad_cnt_q <= pad_cnt_q + 32'd1;
      end else if (shift_c) begin
        in_cnt_q <= in_cnt_q + 32'd1;
      end
      drain_q <= (state_q == S_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
      // Post-fill flag rides alongside the pixel through the datapath registers
      dly_q   <= PIPE_DLY'({dly_q, post_c});
    end
  end

  demosaic_xy_counter #(.WIDTH(WIDTH), .COORD_W(COORD_W)) u_shift_xy (
    .clk   (clk),
    .reset (reset),
    .clr   (start_c),
    .en    (post_c),
    .x     (sx),
    .y     (sy)
  );

  demosaic_xy_counter #(.WIDTH(WIDTH), .COORD_W(COORD_W)) u_out_xy (
    .clk   (clk),
    .reset (reset),
    .clr   (start_c),
    .en    (dly_q[PIPE_DLY-1]),
    .x     (bus.oX),
    .y     (bus.oY)
  );

  // Only the parity bits of the shift-side position feed the Bayer phase
  logic unused_sxy;
  assign unused_sxy = ^{sx[COORD_W-1:1], sy[COORD_W-1:1]};

  assign bus.oReady    = ready_c;
  assign bus.oShiftEn  = shift_c;
  assign bus.oPadSel   = pad_c;
  assign bus.oPhase    = phase_c;
  assign bus.oOutValid = dly_q[PIPE_DLY-1];
  assign bus.oBusy     = (state_q != S_IDLE);
  assign bus.oDone     = (state_q == S_DONE);

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Bench for demosaic_frame_ctrl: drives frames with various upstream/downstream
// patterns and checks the logged shifts and outputs against raster-order expectations.
module tb_demosaic_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int FL = 2;
  localparam int PD = 2;
  localparam int FILL_PIX  = FL * W;
  localparam int FRAME_PIX = W * H;
  localparam int TOTAL_SH  = W * (H + FL);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  demosaic_frame_ctrl_if bus ();

  demosaic_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .FILL_LINES(FL), .PIPE_DLY(PD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         sh_cyc[$];
  logic       sh_pad[$];
  logic [1:0] sh_ph[$];
  int         ov_cyc[$];
  int         ov_x[$];
  int         ov_y[$];
  int         done_cyc[$];
  int         xfer_cnt, xfer_noshift, shift_noxfer;
  bit         timed_out;
  int         stall_bad, stall_ov;
  logic       busy_seen;

  // Passive log of everything the DUT does, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (bus.oShiftEn) begin
        sh_cyc.push_back(cyc);
        sh_pad.push_back(bus.oPadSel);
        sh_ph.push_back(bus.oPhase);
      end
      if (bus.iValid && bus.oReady) begin
        xfer_cnt++;
        if (!(bus.oShiftEn && !bus.oPadSel)) xfer_noshift++;
      end
      if (bus.oShiftEn && !bus.oPadSel && !(bus.iValid && bus.oReady)) shift_noxfer++;
      if (bus.oOutValid) begin
        ov_cyc.push_back(cyc);
        ov_x.push_back(int'(bus.oX));
        ov_y.push_back(int'(bus.oY));
      end
      if (bus.oDone) done_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    sh_cyc.delete(); sh_pad.delete(); sh_ph.delete();
    ov_cyc.delete(); ov_x.delete(); ov_y.delete(); done_cyc.delete();
    xfer_cnt = 0; xfer_noshift = 0; shift_noxfer = 0;
  endtask

  // mode 0: continuous, 1: iValid toggles, 2: random iValid/iOutReady
  task automatic run_frame(input int mode, input int stall_at, input int stall_len,
                           input int restart_at);
    int  c;
    bit  got_done;
    clear_log();
    stall_bad = 0; stall_ov = 0; busy_seen = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b1; bus.iValid = 1'b0; bus.iOutReady = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    c = 0; got_done = 1'b0;
    while (!got_done && c < 3000) begin
      case (mode)
        0:       bus.iValid = 1'b1;
        1:       bus.iValid = (c % 2 == 0);
        default: bus.iValid = ($urandom_range(0, 3) != 0);
      endcase
      bus.iOutReady = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (c >= stall_at && c < stall_at + stall_len) bus.iOutReady = 1'b0;
      bus.iStart = (c == restart_at);
      @(negedge clk);
      if (c >= stall_at && c < stall_at + stall_len) begin
        if (bus.oReady || bus.oShiftEn) stall_bad++;
        if (bus.oOutValid) stall_ov++;
      end
      if (c == restart_at) busy_seen = bus.oBusy;
      if (bus.oDone) got_done = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iOutReady = 1'b1;
    timed_out = !got_done;
    repeat (4) @(negedge clk);
  endtask

  task automatic analyze(input string name);
    int bad, first, k, n;
    logic [1:0] ep;

    checks++;
    if (timed_out) begin
      errors++; $display("FAIL %s done_timeout: no oDone within cycle budget", name);
    end
    checks++;
    if (sh_cyc.size() != TOTAL_SH) begin
      errors++; $display("FAIL %s shift_count: got %0d expected %0d", name, sh_cyc.size(), TOTAL_SH);
    end
    checks++;
    if (xfer_cnt != FRAME_PIX) begin
      errors++; $display("FAIL %s transfer_count: got %0d expected %0d", name, xfer_cnt, FRAME_PIX);
    end
    checks++;
    if (xfer_noshift != 0 || shift_noxfer != 0) begin
      errors++; $display("FAIL %s xfer_vs_shift: xfer_noshift=%0d shift_noxfer=%0d expected 0/0",
                         name, xfer_noshift, shift_noxfer);
    end

    // The first FRAME_PIX shifts carry real pixels, the rest are zero pads
    bad = 0; first = 0;
    for (int i = 0; i < sh_cyc.size(); i++)
      if (sh_pad[i] !== (i >= FRAME_PIX)) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s pad_sel: %0d wrong, first shift %0d got %b expected %b",
                         name, bad, first, sh_pad[first], (first >= FRAME_PIX));
    end

    // Bayer phase follows raster position of each post-fill shift
    bad = 0; first = 0;
    for (int i = 0; i < sh_cyc.size(); i++) begin
      k = i - FILL_PIX;
      ep = 2'b00;
      if (k >= 0) begin
        ep[1] = ((k / W) % 2) == 1;
        ep[0] = ((k % W) % 2) == 1;
      end
      if (sh_ph[i] !== ep) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s phase: %0d wrong, first shift %0d got %0d", name, bad, first, sh_ph[first]);
    end

    checks++;
    if (ov_cyc.size() != FRAME_PIX) begin
      errors++; $display("FAIL %s out_valid_count: got %0d expected %0d", name, ov_cyc.size(), FRAME_PIX);
    end

    n = (ov_cyc.size() < FRAME_PIX) ? ov_cyc.size() : FRAME_PIX;
    bad = 0; first = 0;
    for (int i = 0; i < n; i++)
      if (ov_x[i] != i % W || ov_y[i] != i / W) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s coords: %0d wrong, output %0d got (%0d,%0d) expected (%0d,%0d)",
                         name, bad, first, ov_x[first], ov_y[first], first % W, first / W);
    end

    bad = 0; first = 0;
    for (int i = 0; i < n; i++)
      if (FILL_PIX + i >= sh_cyc.size() || ov_cyc[i] - sh_cyc[FILL_PIX + i] != PD) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s latency: %0d outputs not %0d cycles after their shift, first %0d",
                         name, bad, PD, first);
    end

    checks++;
    if (done_cyc.size() != 1) begin
      errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cyc.size());
    end
    checks++;
    if (done_cyc.size() < 1 || ov_cyc.size() < 1 || done_cyc[0] != ov_cyc[ov_cyc.size()-1] + 1) begin
      errors++; $display("FAIL %s done_timing: done pulse not one cycle after last out_valid (done=%0d ov=%0d)",
                         name, done_cyc.size(), ov_cyc.size());
    end
  endtask

  task automatic test_reset();
    logic [39:0] v;
    bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iOutReady = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    v = {bus.oReady, bus.oShiftEn, bus.oPadSel, bus.oPhase, bus.oOutValid,
         bus.oX, bus.oY, bus.oBusy, bus.oDone};
    checks++;
    if (v !== 40'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", v);
    end
  endtask

  task automatic test_continuous();
    run_frame(0, -1, 0, -1);
    analyze("continuous");
  endtask

  task automatic test_bubbles();
    run_frame(1, -1, 0, -1);
    analyze("bubbles");
  endtask

  task automatic test_stall();
    // Cycles 16..31 of a continuous frame are RUN; stall five of them
    run_frame(0, 20, 5, -1);
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL stall_blocks: %0d stall cycles with oReady/oShiftEn high, expected 0", stall_bad);
    end
    checks++;
    if (stall_ov != PD) begin
      errors++; $display("FAIL stall_inflight: got %0d outputs during stall expected %0d", stall_ov, PD);
    end
    analyze("stall");
  endtask

  task automatic test_ignore();
    int bad;
    clear_log();
    bad = 0;
    bus.iValid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.oReady || bus.oShiftEn || bus.oBusy) bad++;
    end
    @(posedge clk); #1;
    bus.iValid = 1'b0;
    checks++;
    if (bad != 0 || sh_cyc.size() != 0 || xfer_cnt != 0) begin
      errors++; $display("FAIL idle_valid: bad=%0d shifts=%0d xfers=%0d expected 0/0/0",
                         bad, sh_cyc.size(), xfer_cnt);
    end
    run_frame(0, -1, 0, 20);
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++; $display("FAIL start_in_run_busy: got %b expected 1", busy_seen);
    end
    analyze("start_ignored");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      run_frame(2, -1, 0, -1);
      analyze($sformatf("random%0d", f));
    end
  endtask

  task automatic test_reset_mid_flush();
    int c;
    logic [39:0] v;
    clear_log();
    @(posedge clk); #1;
    bus.iStart = 1'b1; bus.iValid = 1'b1; bus.iOutReady = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    c = 0;
    @(negedge clk);
    while (!bus.oPadSel && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!bus.oPadSel) begin
      errors++; $display("FAIL reset_mid_reach_flush: oPadSel never rose within 200 cycles");
    end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    v = {bus.oReady, bus.oShiftEn, bus.oPadSel, bus.oPhase, bus.oOutValid,
         bus.oX, bus.oY, bus.oBusy, bus.oDone};
    checks++;
    if (v !== 40'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0", v);
    end
    bus.iValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    repeat (40) @(negedge clk);
    checks++;
    if (done_cyc.size() != 0 || sh_cyc.size() != 0 || ov_cyc.size() != 0) begin
      errors++; $display("FAIL reset_mid_abandon: done=%0d shifts=%0d outs=%0d expected 0/0/0",
                         done_cyc.size(), sh_cyc.size(), ov_cyc.size());
    end
    run_frame(0, -1, 0, -1);
    analyze("after_reset");
  endtask

  initial begin
    bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iOutReady = 1'b1;
    test_reset();
    test_continuous();
    test_bubbles();
    test_stall();
    test_ignore();
    test_random();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
